// File: rtl/count_multimode.sv
// rtl/count_multimode.sv - parametrised up/down counter with wrap, saturate, ping-pong and one-shot modes
module count_multimode #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = (2 ** WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ctrl,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    MODE_WRAP = 2'b00,
    MODE_SAT  = 2'b01,
    MODE_PING = 2'b10,
    MODE_ONE  = 2'b11
  } mode_t;

  // Effective direction; in ping-pong mode this is the FSM state.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_t;

  // Bounds in both the extended (WIDTH+1) and native widths.
  localparam logic [WIDTH:0]   MAX_W     = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_W     = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_C     = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_DEC_C = WIDTH'(MAX_VAL - 1);
  localparam logic [WIDTH-1:0] ZERO_C    = '0;
  localparam logic [WIDTH-1:0] ONE_C     = WIDTH'(1);

  mode_t            mode_s;
  logic [WIDTH-1:0] count_q, count_d;
  dir_t             dir_q, dir_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   cnt_ext, inc_ext, dec_ext, load_ext;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_dir;
  logic             at_max, at_zero, at_bound;
  logic             step_hits_bound;

  assign mode_s = mode_t'(mode);

  // Widened arithmetic: overshoot past MAX_VAL and borrow below zero are
  // visible in the extra top bit, so bound detection needs no special cases.
  assign cnt_ext  = {1'b0, count_q};
  assign inc_ext  = cnt_ext + ONE_W;
  assign dec_ext  = cnt_ext - ONE_W;
  assign load_ext = {1'b0, load_val};

  assign at_max   = (inc_ext > MAX_W);
  assign at_zero  = dec_ext[WIDTH];
  assign at_bound = (dir_q == DIR_UP) ? at_max : at_zero;

  // Loads are clamped so count can never hold a value above MAX_VAL.
  assign load_clamped = (load_ext > MAX_W) ? MAX_C : load_val;

  // One step in the registered direction; only used when not at a bound.
  assign step_dir = (dir_q == DIR_UP) ? inc_ext[WIDTH-1:0] : dec_ext[WIDTH-1:0];

  // One-shot completes on the edge whose step lands on the bound.
  assign step_hits_bound = (dir_q == DIR_UP) ? (step_dir == MAX_C) : (step_dir == ZERO_C);

  // State register: count, direction and sticky one-shot flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= ZERO_C;
      dir_q   <= DIR_UP;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Next-state: load beats enable; direction follows ctrl except in ping-pong.
  always_comb begin
    count_d = count_q;
    dir_d   = (mode_s == MODE_PING) ? dir_q : dir_t'(ctrl);
    done_d  = (mode_s == MODE_ONE) ? done_q : 1'b0;

    if (load) begin
      count_d = load_clamped;
      dir_d   = dir_t'(ctrl);
      done_d  = 1'b0;
    end else if (en) begin
      case (mode_s)
        MODE_WRAP: begin
          if (at_bound) begin
            count_d = (dir_q == DIR_UP) ? ZERO_C : MAX_C;
          end else begin
            count_d = step_dir;
          end
        end
        MODE_SAT: begin
          if (!at_bound) begin
            count_d = step_dir;
          end
        end
        MODE_PING: begin
          // Bounce without dwelling: leave the bound and flip direction together.
          if (at_bound) begin
            if (dir_q == DIR_UP) begin
              count_d = MAX_DEC_C;
              dir_d   = DIR_DOWN;
            end else begin
              count_d = ONE_C;
              dir_d   = DIR_UP;
            end
          end else begin
            count_d = step_dir;
          end
        end
        default: begin
          // One-shot: saturate-style stepping, frozen once done is set.
          if (!done_q) begin
            if (at_bound) begin
              done_d = 1'b1;
            end else begin
              count_d = step_dir;
              done_d  = step_hits_bound;
            end
          end
        end
      endcase
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign done  = done_q;
  assign tc    = en & ~load & at_bound & ~((mode_s == MODE_ONE) & done_q);

endmodule

// File: tb/tb_count_multimode.sv
// tb/tb_count_multimode.sv - directed table-driven bench for count_multimode
module tb_count_multimode;

  logic       clk;
  logic       rst;
  logic       en;
  logic       ctrl;
  logic [1:0] mode;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       dir;
  logic       tc;
  logic       done;

  logic       en_b;
  logic       ctrl_b;
  logic [1:0] mode_b;
  logic       load_b;
  logic [1:0] load_val_b;
  logic [1:0] count_b;
  logic       dir_b;
  logic       tc_b;
  logic       done_b;

  count_multimode #(.WIDTH(4), .MAX_VAL(9)) dut (
    .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .mode(mode), .load(load),
    .load_val(load_val), .count(count), .dir(dir), .tc(tc), .done(done)
  );

  count_multimode #(.WIDTH(2), .MAX_VAL(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .ctrl(ctrl_b), .mode(mode_b), .load(load_b),
    .load_val(load_val_b), .count(count_b), .dir(dir_b), .tc(tc_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       load;
    logic       en;
    logic       ctrl;
    logic [1:0] mode;
    logic [3:0] lv;
    logic       e_tc;
    logic [3:0] e_cnt;
    logic       e_dir;
    logic       e_done;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input int r, input int ld, input int e, input int c, input int m,
                              input int lv, input int t, input int cnt, input int d, input int dn);
    vec_t v;
    v.rst    = 1'(r);
    v.load   = 1'(ld);
    v.en     = 1'(e);
    v.ctrl   = 1'(c);
    v.mode   = 2'(m);
    v.lv     = 4'(lv);
    v.e_tc   = 1'(t);
    v.e_cnt  = 4'(cnt);
    v.e_dir  = 1'(d);
    v.e_done = 1'(dn);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // tc is checked before the edge with the vector's inputs applied;
  // registered outputs are checked just after the edge.
  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    rst      = v.rst;
    load     = v.load;
    en       = v.en;
    ctrl     = v.ctrl;
    mode     = v.mode;
    load_val = v.lv;
    #1;
    chk($sformatf("v%0d tc", idx), 32'(tc), 32'(v.e_tc));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d count", idx), 32'(count), 32'(v.e_cnt));
    chk($sformatf("v%0d dir", idx), 32'(dir), 32'(v.e_dir));
    chk($sformatf("v%0d done", idx), 32'(done), 32'(v.e_done));
  endtask

  initial begin
    int pp_cnt[13] = '{8, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int pp_dir[13] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    int pp_tc[13]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    int b_cnt[4]   = '{1, 0, 1, 0};
    int b_tc[4]    = '{0, 1, 1, 1};

    rst = 1'b1; en = 1'b0; ctrl = 1'b1; mode = 2'b00; load = 1'b0; load_val = 4'd0;
    en_b = 1'b0; ctrl_b = 1'b0; mode_b = 2'b10; load_b = 1'b0; load_val_b = 2'd0;

    // wrap up 0..9 then 0
    for (int c = 0; c < 10; c++) vecs.push_back(mk(0, 0, 1, 1, 0, 0, (c == 9), (c + 1) % 10, 1, 0));
    // set dir down with en=0, then wrap down 0,9,8..1,0
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 11; k++) begin
      int pre;
      pre = (k == 0) ? 0 : (10 - k);
      vecs.push_back(mk(0, 0, 1, 0, 0, 0, (pre == 0), (pre == 0) ? 9 : pre - 1, 0, 0));
    end
    // saturate: clamped load, hold at top, reverse, run to bottom and hold
    vecs.push_back(mk(0, 1, 1, 1, 1, 15, 0, 9, 1, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 9, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 9, 0, 0));
    for (int pre = 9; pre >= 1; pre--) vecs.push_back(mk(0, 0, 1, 0, 1, 0, 0, pre - 1, 0, 0));
    for (int k = 0; k < 2; k++) vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0));
    // ping-pong from 7 with ctrl toggling
    vecs.push_back(mk(0, 1, 1, 1, 2, 7, 0, 7, 1, 0));
    for (int i = 0; i < 13; i++) vecs.push_back(mk(0, 0, 1, i % 2, 2, 0, pp_tc[i], pp_cnt[i], pp_dir[i], 0));
    // one-shot
    vecs.push_back(mk(0, 1, 1, 1, 3, 6, 0, 6, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 3, 0, 0, 7, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 3, 0, 0, 8, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 3, 0, 0, 9, 1, 1));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0, 0, 1, 0, 3, 0, 0, 9, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 3, 2, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 3, 0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 1, 3, 0, 0, 0, 1, 1));
    // enable / load priority and clamp edges
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 5, 0, 5, 1, 0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 5, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 3, 0, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 10, 0, 9, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 9, 0, 9, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 7, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 1, 0));

    // reset, then asynchronous reset mid-count
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset count", 32'(count), 32'd0);
    chk("reset dir", 32'(dir), 32'd1);
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk);
    load = 1'b1; load_val = 4'd5; en = 1'b1;
    @(posedge clk);
    #1;
    chk("preload count", 32'(count), 32'd5);
    @(negedge clk);
    load = 1'b0; en = 1'b0; ctrl = 1'b0;
    @(posedge clk);
    #1;
    chk("pre-async dir", 32'(dir), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("async count", 32'(count), 32'd0);
    chk("async dir", 32'(dir), 32'd1);
    chk("async done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0; en = 1'b1; ctrl = 1'b1; mode = 2'b00;
    @(posedge clk);
    #1;
    chk("post-reset step1", 32'(count), 32'd1);
    @(posedge clk);
    #1;
    chk("post-reset step2", 32'(count), 32'd2);
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) apply(i, vecs[i]);

    // ping-pong with MAX_VAL=1 on the narrow instance: 0,1,0,1,0
    @(negedge clk);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    en_b = 1'b1; mode_b = 2'b10; ctrl_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("b%0d tc", i), 32'(tc_b), 32'(b_tc[i]));
      @(posedge clk);
      #1;
      chk($sformatf("b%0d count", i), 32'(count_b), 32'(b_cnt[i]));
      chk($sformatf("b%0d dir", i), 32'(dir_b), 32'(b_cnt[i]));
      chk($sformatf("b%0d done", i), 32'(done_b), 32'd0);
      @(negedge clk);
      ctrl_b = ~ctrl_b;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/count_multimode.md
Name: count_multimode

Overview:
- Parametrised successor to the team's 4-bit special counter.
- Up/down counter with programmable width and terminal value, synchronous load, and clock enable.
- Four run modes: wrap, saturate, ping-pong and one-shot.
- Used as the general-purpose counter for lab datapaths, for example digit scanning, timers and LED sequencers.

Parameters:
- WIDTH, 4: counter width in bits; must be >= 2.
- MAX_VAL, 2**WIDTH-1: upper count bound; legal range is 1..2**WIDTH-1; the counter range is 0..MAX_VAL.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  count enable; when 0, the count holds.
- ctrl  in  1  direction request: 1 = up, 0 = down.
- mode  in  2  00 wrap, 01 saturate, 10 ping-pong, 11 one-shot.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value loaded when load=1.
- count  out  WIDTH  current count, registered.
- dir  out  1  current effective direction, registered: 1 = up.
- tc  out  1  terminal-count flag, combinational from registers and inputs.
- done  out  1  one-shot finished flag, registered and sticky.

Behaviour:
- Reset:
  - rst=1 asynchronously forces count=0, dir=1, done=0, at any time, including mid-count.
  - First update happens on the first rising edge after rst deasserts.
- Priority per edge: rst > load > en > hold.
- Load:
  - load=1: count <= min(load_val, MAX_VAL); done <= 0; dir <= ctrl. This applies in all modes, including mode 10.
  - Load is independent of en.
- Direction register:
  - In modes 00, 01 and 11: dir <= ctrl every cycle, regardless of en.
  - In mode 10: dir is internal state {UP, DOWN} and ignores ctrl; it toggles only at bounds.
- Bounds: "at bound" means (dir=1 and count==MAX_VAL) or (dir=0 and count==0). Direction is the registered dir.
- Per edge with en=1, load=0:
  - mode 00 wrap: up increments, MAX_VAL->0; down decrements, 0->MAX_VAL.
  - mode 01 saturate: up stops at MAX_VAL and down stops at 0; reversing ctrl leaves the bound on the next enabled edge.
  - mode 10 ping-pong:
    - UP at MAX_VAL: count <= MAX_VAL-1 and dir <= 0.
    - DOWN at 0: count <= 1 and dir <= 1.
    - Otherwise step in dir.
    - No dwell at bounds. With MAX_VAL=1 the sequence is 0,1,0,1.
  - mode 11 one-shot:
    - While done=0, step as in saturate.
    - On the edge where count reaches the bound in the current dir, done <= 1.
    - While done=1, count freezes even if ctrl or mode change. Only load or rst clears it.
    - If count already sits at the bound when the mode is entered, done <= 1 on the next enabled edge and count holds.
- dir update uses the same-edge ctrl: a flip of ctrl takes effect one edge later in stepping, because stepping uses registered dir.
- tc = en & ~load & at_bound, for modes 00, 01 and 10.
  - In mode 11: tc = en & ~load & at_bound & ~done.
- done is forced 0 in modes 00, 01 and 10.
  - A mode change out of 11 clears done on the next edge.
- Mode changes take effect on the next edge and do not reset count.
  - Entering mode 10: dir keeps its last value.
- Out-of-range states cannot occur, because loads are clamped.
- Internal arithmetic is WIDTH+1 bits to detect bounds; count never holds a value above MAX_VAL.

Test Plan (WIDTH=4, MAX_VAL=9 unless stated):
- Reset: rst=1 mid-count at count=5 between edges -> count=0, dir=1, done=0 immediately, without waiting for a clock. Release and run mode 00 with ctrl=1, en=1 -> 1,2,... on successive edges.
- Wrap up: mode 00, ctrl=1, en=1 from 0 -> count 0..9 then 0; tc=1 only while count=9. Wrap down: ctrl=0 from 0 -> 9,8,...; tc=1 while count=0.
- Saturate and clamp:
  - mode 01, load_val=15 -> count=9, clamped.
  - ctrl=1 for 3 edges -> count stays 9 with tc=1.
  - ctrl=0 -> 9, then 8 on the following edge, then 7.
- Ping-pong: mode 10 from 7, dir=1 -> 8,9,8,7,...,1,0,1; dir toggles on the edges leaving 9 and 0; ctrl toggling has no effect.
- One-shot:
  - mode 11, load 6, ctrl=1 -> 7,8,9; done=1 on the edge reaching 9.
  - ctrl=0 and en=1 for 4 edges -> count stays 9 and done stays 1.
  - load=1 with load_val=2 -> count=2, done=0.
- Enable and load priority: en=0 for 5 edges -> count holds. load=1 with en=0 and load_val=3 -> count=3. load=1 and rst=1 together -> count=0.
